vend_dispense_ctrl: RTL and testbench

Sequences the physical vend after the vending FSM authorises a purchase. It drives the spiral motor of the selected slot and waits for the drop sensor. It then pays out change greedily, one coin at a time, through a valid/ack handshake with the coin hopper. On a motor timeout it refunds the full credit instead of change and reports a fault.

---
 rtl/vend_dispense_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl
// Runs the physical part of a purchase. It spins the selected spiral motor
// until the drop sensor fires or the motor times out. It then pays change
// greedily, one coin per hopper handshake. On a timeout it refunds the full
// credit. It ends with a one-cycle done or fault pulse.
module vend_dispense_ctrl #(
  parameter int NUM_ITEMS     = 4,
  parameter int ITEM_W        = 2,
  parameter int MOTOR_TIMEOUT = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vend_req,
  input  logic [ITEM_W-1:0]    vend_item,
  input  logic [7:0]           change_cents,
  input  logic [7:0]           credit_cents,
  input  logic                 drop_sensor,
  input  logic                 hopper_ack,
  output logic [NUM_ITEMS-1:0] motor_en,
  output logic                 coin_valid,
  output logic [1:0]           coin_sel,
  output logic                 busy,
  output logic                 vend_done,
  output logic                 vend_fault
);

  localparam int CNT_W = $clog2(MOTOR_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOTOR_TIMEOUT - 1);

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MOTOR,
    CHANGE,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           rem_q, rem_d;
  logic [7:0]           credit_q, credit_d;
  logic                 fault_q, fault_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_ITEMS-1:0] motor_d;
  logic                 coin_valid_d;
  logic [1:0]           coin_sel_d;
  logic                 busy_d;
  logic                 done_d;
  logic                 fault_pulse_d;

  logic [NUM_ITEMS-1:0] slot_onehot;
  logic [1:0]           pick_sel;
  logic [7:0]           pick_value;

  // Decode the requested slot. An out-of-range index shifts out to zero and falls back to slot 0.
  always_comb begin
    slot_onehot = NUM_ITEMS'(1) << vend_item;
    if (slot_onehot == '0) begin
      slot_onehot = NUM_ITEMS'(1);
    end
  end

  // Greedy coin choice from the amount still owed; COIN_NONE means the residue is below a nickel.
  always_comb begin
    pick_sel   = COIN_NONE;
    pick_value = 8'd0;
    if (rem_q >= 8'd25) begin
      pick_sel   = COIN_QUARTER;
      pick_value = 8'd25;
    end else if (rem_q >= 8'd10) begin
      pick_sel   = COIN_DIME;
      pick_value = 8'd10;
    end else if (rem_q >= 8'd5) begin
      pick_sel   = COIN_NICKEL;
      pick_value = 8'd5;
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    credit_d      = credit_q;
    fault_d       = fault_q;
    cnt_d         = cnt_q;
    motor_d       = motor_en;
    coin_valid_d  = coin_valid;
    coin_sel_d    = coin_sel;
    busy_d        = busy;
    done_d        = 1'b0;
    fault_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (vend_req) begin
          rem_d    = change_cents;
          credit_d = credit_cents;
          fault_d  = 1'b0;
          cnt_d    = '0;
          motor_d  = slot_onehot;
          busy_d   = 1'b1;
          state_d  = MOTOR;
        end
      end

      MOTOR: begin
        // A drop seen on the final timeout cycle still counts as success.
        if (drop_sensor) begin
          motor_d = '0;
          fault_d = 1'b0;
          state_d = CHANGE;
        end else if (cnt_q == CNT_LAST) begin
          motor_d = '0;
          fault_d = 1'b1;
          rem_d   = credit_q;
          state_d = CHANGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CHANGE: begin
        // With no coin outstanding this is the selection cycle. That gives the idle gap between coins.
        if (!coin_valid) begin
          if (pick_sel != COIN_NONE) begin
            coin_valid_d = 1'b1;
            coin_sel_d   = pick_sel;
          end else begin
            state_d       = DONE;
            done_d        = ~fault_q;
            fault_pulse_d = fault_q;
          end
        end else if (hopper_ack) begin
          // The amount owed is unchanged while the coin waits, so pick_value still matches coin_sel.
          rem_d        = rem_q - pick_value;
          coin_valid_d = 1'b0;
          coin_sel_d   = COIN_NONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= 8'd0;
      credit_q   <= 8'd0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
      motor_en   <= '0;
      coin_valid <= 1'b0;
      coin_sel   <= COIN_NONE;
      busy       <= 1'b0;
      vend_done  <= 1'b0;
      vend_fault <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      credit_q   <= credit_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
      motor_en   <= motor_d;
      coin_valid <= coin_valid_d;
      coin_sel   <= coin_sel_d;
      busy       <= busy_d;
      vend_done  <= done_d;
      vend_fault <= fault_pulse_d;
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Testbench for vend_dispense_ctrl.
// A stimulus process issues vends and pushes the expected outcome of each vend into a scoreboard.
// Reactive responders model the drop sensor and the coin hopper.
// A negedge monitor collects what the DUT did and compares it when a done or fault pulse appears.
module tb_vend_dispense_ctrl;

  localparam int NUM_ITEMS = 4;
  localparam int ITEM_W    = 2;
  localparam int T         = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 vend_req = 1'b0;
  logic [ITEM_W-1:0]    vend_item = '0;
  logic [7:0]           change_cents = 8'd0;
  logic [7:0]           credit_cents = 8'd0;
  logic                 drop_sensor = 1'b0;
  logic                 hopper_ack = 1'b0;
  logic [NUM_ITEMS-1:0] motor_en;
  logic                 coin_valid;
  logic [1:0]           coin_sel;
  logic                 busy;
  logic                 vend_done;
  logic                 vend_fault;

  vend_dispense_ctrl #(
    .NUM_ITEMS(NUM_ITEMS),
    .ITEM_W(ITEM_W),
    .MOTOR_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vend_req(vend_req),
    .vend_item(vend_item),
    .change_cents(change_cents),
    .credit_cents(credit_cents),
    .drop_sensor(drop_sensor),
    .hopper_ack(hopper_ack),
    .motor_en(motor_en),
    .coin_valid(coin_valid),
    .coin_sel(coin_sel),
    .busy(busy),
    .vend_done(vend_done),
    .vend_fault(vend_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_fault;
    int          onehot;
    int          motor_cycles;
    logic [31:0] coins;
    int          n_coins;
    int          cents;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   ack_delays[$];
  int   checks = 0;
  int   passes = 0;
  int   drop_plan = 0;
  bit   noise = 1'b0;

  task automatic checkOutput(input string name, input int got, input int req);
    checks++;
    if (got == req) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
  endtask

  function automatic int coinCents(input logic [1:0] code);
    case (code)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 25;
      default: return 0;
    endcase
  endfunction

  // Drop-sensor model: the item falls during the drop_plan-th motor cycle; otherwise optional noise.
  int mcount = 0;
  always @(negedge clk) begin
    if (motor_en != '0) begin
      mcount++;
      drop_sensor = (mcount == drop_plan);
    end else begin
      mcount = 0;
      drop_sensor = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor plus hopper responder, kept in one process so the monitor sees exactly the ack it drove.
  int          motor_cnt = 0;
  logic [3:0]  motor_or = '0;
  logic [31:0] coins_obs = '0;
  int          n_obs = 0;
  int          cents_obs = 0;
  bit          expect_idle = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_ack = 1'b0;
  bit          prev_reset = 1'b0;
  logic [1:0]  prev_sel = 2'b00;
  bit          in_coin = 1'b0;
  int          wait_cnt = 0;
  int          cur_k = 0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_reset) begin
      checkOutput("reset_outputs",
                  int'({motor_en, coin_valid, coin_sel, busy, vend_done, vend_fault}), 0);
      sb.delete();
      ack_delays.delete();
      motor_cnt = 0; motor_or = '0; coins_obs = '0; n_obs = 0; cents_obs = 0;
      expect_idle = 1'b0;
    end else if (!reset) begin
      if (expect_idle) begin
        checkOutput("busy_low_after_done", int'(busy), 0);
        expect_idle = 1'b0;
      end
      if (prev_valid && !prev_ack)
        checkOutput("coin_hold", int'({coin_valid, coin_sel}), int'({1'b1, prev_sel}));
      if (prev_valid && prev_ack) begin
        checkOutput("coin_gap", int'(coin_valid), 0);
        coins_obs = {coins_obs[29:0], prev_sel};
        n_obs++;
        cents_obs += coinCents(prev_sel);
      end
      if (motor_en != '0) begin
        motor_or |= motor_en;
        motor_cnt++;
      end
      if (vend_done || vend_fault) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse", int'({vend_fault, vend_done}), 0);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind", int'({vend_fault, vend_done}), e.is_fault ? 2 : 1);
          checkOutput("busy_in_done", int'(busy), 1);
          checkOutput("motor_slot", int'(motor_or), e.onehot);
          checkOutput("motor_cycles", motor_cnt, e.motor_cycles);
          checkOutput("coin_count", n_obs, e.n_coins);
          checkOutput("coin_sequence", int'(coins_obs), int'(e.coins));
          checkOutput("cents_paid", cents_obs, e.cents);
          checkOutput("done_cycle", cyc, e.done_cyc);
        end
        motor_cnt = 0; motor_or = '0; coins_obs = '0; n_obs = 0; cents_obs = 0;
        expect_idle = 1'b1;
      end
    end

    if (reset || prev_reset) begin
      hopper_ack = 1'b0;
      in_coin = 1'b0;
    end else if (coin_valid) begin
      if (!in_coin) begin
        in_coin = 1'b1;
        wait_cnt = 0;
        cur_k = (ack_delays.size() != 0) ? ack_delays.pop_front() : 0;
      end
      if (wait_cnt == cur_k) begin
        hopper_ack = 1'b1;
        in_coin = 1'b0;
      end else begin
        hopper_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      in_coin = 1'b0;
      hopper_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    prev_valid = coin_valid;
    prev_sel   = coin_sel;
    prev_ack   = hopper_ack;
    prev_reset = reset;
  end

  // Reference model: greedy change from plain division, with latency from motor time and coin waits.
  task automatic issueVend(input int item, input int change, input int credit,
                           input int drop_at, input int delay, input bit extra);
    exp_t e;
    int   rem, q, d, n, lat, k;
    bit   ok;
    ok = (drop_at != 0) && (drop_at <= T);
    e.is_fault = !ok;
    e.motor_cycles = ok ? drop_at : T;
    e.onehot = 1 << item;
    rem = ok ? change : credit;
    q = rem / 25; rem = rem % 25;
    d = rem / 10; rem = rem % 10;
    n = rem / 5;
    e.n_coins = q + d + n;
    e.cents = 25 * q + 10 * d + 5 * n;
    e.coins = '0;
    for (int i = 0; i < q; i++) e.coins = {e.coins[29:0], 2'b11};
    for (int i = 0; i < d; i++) e.coins = {e.coins[29:0], 2'b10};
    for (int i = 0; i < n; i++) e.coins = {e.coins[29:0], 2'b01};
    lat = e.motor_cycles + 1;
    for (int i = 0; i < e.n_coins; i++) begin
      k = (delay < 0) ? int'($urandom_range(0, 4)) : delay;
      ack_delays.push_back(k);
      lat += k + 2;
    end
    drop_plan = drop_at;
    @(posedge clk); #1;
    vend_req = 1'b1;
    vend_item = ITEM_W'(item);
    change_cents = 8'(change);
    credit_cents = 8'(credit);
    e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    vend_req = 1'b0;
    if (extra) begin
      vend_req = 1'b1;
      vend_item = ITEM_W'((item + 1) % NUM_ITEMS);
      change_cents = 8'd95;
      credit_cents = 8'd200;
      @(posedge clk); #1;
      vend_req = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int item, input int change, input int credit,
                               input int drop_at, input int delay, input bit extra);
    bit finished;
    issueVend(item, change, credit, drop_at, delay, extra);
    finished = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    checkOutput("sequence_completes", int'(finished), 1);
    @(negedge clk);
  endtask

  task automatic abortWithReset();
    bit seen;
    issueVend(2, 35, 100, 2, 6, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (coin_valid && coin_sel == 2'b10) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("dime_request_seen", int'(seen), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int item, credit, change, drop_at;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] normal vend with change");
    applyStimulus(2, 40, 100, 3, 1, 1'b0);
    $display("[TB] exact payment");
    applyStimulus(0, 0, 50, 1, 0, 1'b0);
    $display("[TB] motor timeout refund");
    applyStimulus(1, 10, 35, 0, 1, 1'b0);
    $display("[TB] hopper stall with stray acks");
    noise = 1'b1;
    applyStimulus(3, 5, 20, 2, 6, 1'b0);
    noise = 1'b0;
    $display("[TB] second request while busy");
    applyStimulus(0, 15, 40, 4, 0, 1'b1);
    $display("[TB] reset during dime request");
    abortWithReset();
    applyStimulus(1, 20, 60, 2, 0, 1'b0);
    $display("[TB] residue discarded");
    applyStimulus(3, 27, 80, 5, 2, 1'b0);
    $display("[TB] drop on timeout cycle");
    applyStimulus(2, 30, 90, T, 0, 1'b0);

    $display("[TB] randomized vends");
    for (int i = 0; i < 30; i++) begin
      item    = int'($urandom_range(0, NUM_ITEMS - 1));
      credit  = int'($urandom_range(0, 120));
      change  = int'($urandom_range(0, credit));
      drop_at = int'($urandom_range(0, T + 2));
      noise   = 1'($urandom_range(0, 1));
      applyStimulus(item, change, credit, drop_at, -1, 1'($urandom_range(0, 1)));
    end
    noise = 1'b0;

    checkOutput("unmatched_expectations", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
